// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button/mode-switch input stage.
// The top level and the benches both read these, so channel counts and the debounce default stay in one place.
package button_conditioner_pkg;

    localparam int N_BUTTONS   = 4;
    localparam int N_MODE      = 2;
    localparam int N_CHANNELS  = N_BUTTONS + N_MODE;

    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 10 ms of settling at the system clock rate.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side and conditioned-side signals of the button conditioner.
// The slave side is the conditioner; the master side drives the raw pins and consumes the outputs.
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic [N_BUTTONS-1:0] buttons_raw_i;
    logic [N_MODE-1:0]    mode_raw_i;
    logic [N_BUTTONS-1:0] buttons_o;
    logic [N_BUTTONS-1:0] press_o;
    logic [N_MODE-1:0]    mode_o;

    modport slave (
        input  buttons_raw_i,
        input  mode_raw_i,
        output buttons_o,
        output press_o,
        output mode_o
    );

    modport master (
        output buttons_raw_i,
        output mode_raw_i,
        input  buttons_o,
        input  press_o,
        input  mode_o
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One input channel: two-flop synchronizer, then a level that only flips after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic raw_i,
    output logic q_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            q   <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw_i;
            s2 <= s1;
            // A single agreeing cycle throws away any partial count.
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                q   <= s2;
                cnt <= '0;
            end
        end
    end

    assign q_o    = q;
    // High in the cycle before q goes 0->1, so a register fed by it lines up with q.
    assign rise_o = s2 & ~q & (cnt == CNT_MAX);

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the push-buttons and mode switches, and emits a
// one-cycle registered pulse on each debounced button press.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    button_conditioner_if.slave  bus
);

    logic [N_BUTTONS-1:0] buttons_q;
    logic [N_BUTTONS-1:0] buttons_rise;
    logic [N_MODE-1:0]    mode_q;
    logic [N_MODE-1:0]    mode_rise_unused;
    logic [N_BUTTONS-1:0] press_q;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_button
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clock_i  (clock_i),
            .reset_ni (reset_ni),
            .raw_i    (bus.buttons_raw_i[i]),
            .q_o      (buttons_q[i]),
            .rise_o   (buttons_rise[i])
        );
    end

    // Mode switches are levels only; their edge indication has no consumer.
    for (genvar i = 0; i < N_MODE; i++) begin : g_mode
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clock_i  (clock_i),
            .reset_ni (reset_ni),
            .raw_i    (bus.mode_raw_i[i]),
            .q_o      (mode_q[i]),
            .rise_o   (mode_rise_unused[i])
        );
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            press_q <= '0;
        end else begin
            press_q <= buttons_rise;
        end
    end

    assign bus.buttons_o = buttons_q;
    assign bus.press_o   = press_q;
    assign bus.mode_o    = mode_q;

endmodule
